// File: rtl/wsc_pkg.sv
// Shared types for the write-sequence checker: FSM state encoding and the
// helper that sizes the match-index port.
package wsc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_HOLD = 3'd2,
        ST_PASS = 3'd3,
        ST_FAIL = 3'd4
    } wsc_state_t;

    localparam int CNT_W = 32;

    // Wide enough to hold every value from 0 up to and including num_checks.
    function automatic int idx_width(input int num_checks);
        return $clog2(num_checks + 1);
    endfunction

endpackage

// File: rtl/wsc_timeout_ctr.sv
// Saturating run-cycle counter with a terminal-count flag at TIMEOUT_CYCLES-1.
// Clear has priority over enable.
module wsc_timeout_ctr
    import wsc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == TC_VAL);

endmodule

// File: rtl/write_seq_checker.sv
// Watches processor stores for an ordered list of expected (address, data)
// pairs; reports pass/fail and requests a stop. Optional WSC_STRICT_ORDER_EN
// turns out-of-order or wrong-data writes to expected addresses into a fail.
module write_seq_checker
    import wsc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HOLD_CYCLES    = 3,
    parameter logic [NUM_CHECKS*ADDR_WIDTH-1:0] EXP_ADDR = '0,
    parameter logic [NUM_CHECKS*DATA_WIDTH-1:0] EXP_DATA = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             mem_write,
    input  logic [ADDR_WIDTH-1:0]            address,
    input  logic [DATA_WIDTH-1:0]            wdata,
    output logic                             busy,
    output logic                             pass,
    output logic                             fail,
    output logic                             stop_req,
    output logic [idx_width(NUM_CHECKS)-1:0] match_idx,
    output logic [CNT_W-1:0]                 cycle_cnt,
    output wsc_state_t                       dbg_state_o
);

    localparam int IDX_W = idx_width(NUM_CHECKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    wsc_state_t       state_q;
    logic             busy_q;
    logic             pass_q;
    logic             fail_q;
    logic             stop_q;
    logic [IDX_W-1:0] match_idx_q;
    logic [CNT_W-1:0] hold_q;

    logic [ADDR_WIDTH-1:0] exp_addr_cur;
    logic [DATA_WIDTH-1:0] exp_data_cur;
    logic                  write_in_run;
    logic                  seq_match;
    logic                  final_match;
    logic                  order_viol;
    logic                  timeout_tc;
    logic [CNT_W-1:0]      cnt_value;

    always_comb begin
        exp_addr_cur = '0;
        exp_data_cur = '0;
        for (int k = 0; k < NUM_CHECKS; k++) begin
            if (IDX_W'(k) == match_idx_q) begin
                exp_addr_cur = EXP_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
                exp_data_cur = EXP_DATA[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign write_in_run = (state_q == ST_RUN) && mem_write;
    assign seq_match    = write_in_run && (address == exp_addr_cur) && (wdata == exp_data_cur);
    assign final_match  = seq_match && (match_idx_q == LAST_IDX);

`ifdef WSC_STRICT_ORDER_EN
    logic addr_hit_other;

    // A store to any other expected slot's address means the sequence is out of order.
    always_comb begin
        addr_hit_other = 1'b0;
        for (int k = 0; k < NUM_CHECKS; k++) begin
            if ((IDX_W'(k) != match_idx_q) && (address == EXP_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                addr_hit_other = 1'b1;
            end
        end
    end

    assign order_viol = write_in_run && !seq_match &&
                        (addr_hit_other || (address == exp_addr_cur));
`else
    assign order_viol = 1'b0;
`endif

    wsc_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear_i ((state_q == ST_IDLE) && start),
        .en_i    ((state_q == ST_RUN) || (state_q == ST_HOLD)),
        .count_o (cnt_value),
        .tc_o    (timeout_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            stop_q      <= 1'b0;
            match_idx_q <= '0;
            hold_q      <= '0;
        end else begin
            stop_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        match_idx_q <= '0;
                    end
                end
                ST_RUN: begin
                    // The completing match outranks a timeout landing on the same edge.
                    if (final_match) begin
                        state_q     <= ST_HOLD;
                        match_idx_q <= match_idx_q + 1'b1;
                        hold_q      <= '0;
                    end else if (order_viol || timeout_tc) begin
                        state_q <= ST_FAIL;
                        busy_q  <= 1'b0;
                        fail_q  <= 1'b1;
                        stop_q  <= 1'b1;
                    end else if (seq_match) begin
                        match_idx_q <= match_idx_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hold_q >= HOLD_LAST) begin
                        state_q <= ST_PASS;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b1;
                        stop_q  <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ST_PASS, ST_FAIL: begin
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign stop_req    = stop_q;
    assign match_idx   = match_idx_q;
    assign cycle_cnt   = cnt_value;
    assign dbg_state_o = state_q;

endmodule

// File: doc/write_seq_checker.md
WRITE_SEQ_CHECKER -- requirements
Module: write_seq_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the store-data bus.
REQ-002 Parameter ADDR_WIDTH, default 32: width of the memory-address bus.
REQ-003 Parameter NUM_CHECKS, default 4, range 1..16: number of expected stores in the sequence.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000: cycles from run start before FAIL.
REQ-005 Parameter HOLD_CYCLES, default 3: cycles between final match and stop_req.
REQ-006 Parameter EXP_ADDR, NUM_CHECKS*ADDR_WIDTH, default all zero: packed expected addresses; entry 0 is in the LSBs.
REQ-007 Parameter EXP_DATA, NUM_CHECKS*DATA_WIDTH, default all zero: packed expected data; entry 0 is in the LSBs.
REQ-008 Port clk, in, 1: single clock; all logic samples on the rising edge.
REQ-009 Port reset, in, 1: asynchronous, active-high reset.
REQ-010 Port start, in, 1: one-cycle pulse that begins a run.
REQ-011 Port mem_write, in, 1: the processor's memory write strobe.
REQ-012 Port address, in, ADDR_WIDTH: the processor's memory address.
REQ-013 Port wdata, in, DATA_WIDTH: the store data (register B).
REQ-014 Port busy, out, 1: high in RUN and HOLD.
REQ-015 Port pass, out, 1: sticky pass flag.
REQ-016 Port fail, out, 1: sticky fail flag.
REQ-017 Port stop_req, out, 1: one-cycle pulse that asks the bench to end simulation.
REQ-018 Port match_idx, out, clog2(NUM_CHECKS+1): number of matches so far.
REQ-019 Port cycle_cnt, out, 32: cycles elapsed in the current run.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN, HOLD, PASS and FAIL, encoded as a package enum.
REQ-021 IDLE SHALL move to RUN on start=1; on entry to RUN, cycle_cnt and match_idx SHALL clear to 0.
REQ-022 In RUN, a match SHALL be a cycle with mem_write=1, address==EXP_ADDR[match_idx] and wdata==EXP_DATA[match_idx]; a match SHALL increment match_idx by 1 on the next edge.
REQ-023 The match for entry NUM_CHECKS-1 SHALL move the FSM to HOLD; no other match SHALL leave RUN.
REQ-024 HOLD SHALL count HOLD_CYCLES cycles, then enter PASS; pass SHALL rise and stop_req SHALL pulse for one cycle at that transition.
REQ-025 RUN SHALL enter FAIL when cycle_cnt reaches TIMEOUT_CYCLES-1 without completing; fail SHALL rise and stop_req SHALL pulse for one cycle at that transition.
REQ-026 If a completing match and a timeout fall in the same cycle, the match SHALL win and the FSM SHALL enter HOLD.
REQ-027 cycle_cnt SHALL increment in RUN and HOLD only, and SHALL saturate at 2^32-1.
REQ-028 Writes with mem_write=0 SHALL never match, whatever address and wdata hold.
REQ-029 PASS and FAIL SHALL be terminal; start SHALL be ignored there, and only reset SHALL leave them.
REQ-030 start asserted in RUN or HOLD SHALL be ignored.
REQ-031 All outputs SHALL be registered with no combinational paths from inputs.

Reset
REQ-032 On reset=1, the FSM SHALL go to IDLE asynchronously, and busy, pass, fail, stop_req, match_idx and cycle_cnt SHALL go to 0 immediately.
REQ-033 Reset asserted mid-run SHALL abandon the run, with no pass, fail or stop_req pulse.
REQ-034 Reset SHALL be deasserted synchronously to clk by the bench.

Configuration
REQ-035 Macro WSC_STRICT_ORDER_EN SHALL control ordering checks.
REQ-036 With WSC_STRICT_ORDER_EN defined, a RUN-state write whose address equals any EXP_ADDR[k] with k!=match_idx, or whose address equals EXP_ADDR[match_idx] with wrong data, SHALL enter FAIL next cycle and pulse stop_req.
REQ-037 Without WSC_STRICT_ORDER_EN, all non-matching writes SHALL be ignored.

Structure
REQ-038 Package wsc_pkg SHALL hold the state enum type wsc_state_t and the localparam function for match_idx width.
REQ-039 Sub-module wsc_timeout_ctr SHALL implement the saturating cycle counter with a terminal-count output; all other logic SHALL be inline.

Verification
REQ-040 Defaults with NUM_CHECKS=1, EXP_ADDR=84, EXP_DATA=-4: start, then a write (84,-4) at cycle 20 -> pass=1, stop_req pulses 3 cycles later, match_idx=1.
REQ-041 NUM_CHECKS=2, EXP_ADDR={84,80}, EXP_DATA={7,-4}: writes (80,-4) then (84,7) -> pass; writes in reversed order without the macro -> timeout fail at cycle 999.
REQ-042 With WSC_STRICT_ORDER_EN and NUM_CHECKS=2: write (84,7) first -> fail the next cycle and stop_req pulse.
REQ-043 TIMEOUT_CYCLES=10, completing match on cycle_cnt=9 -> HOLD then pass, with no fail.
REQ-044 Reset asserted in HOLD -> all outputs 0 immediately; no stop_req; a later start gives a clean run.
REQ-045 Write (84,-4) with mem_write=0, then start pulsed in RUN -> no match, no restart, cycle_cnt continues.
